// File: rtl/n2r_stream_buffer_pkg.sv
// Package for the row-to-block stream buffer.
// Holds the slice bank status enum, the default element geometry and the
// index helpers that the banks and the top level use.
package n2r_stream_buffer_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_BLOCK_SIZE = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_st_e;

  // Counter width for a modulo-n count. A count of 1 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Position of element (i,j) inside a packed block. Transposed blocks swap
  // the roles of row and column.
  function automatic int blk_idx(input int i, input int j, input int bs, input logic tr);
    return tr ? (j * bs + i) : (i * bs + j);
  endfunction

  // MSB of element idx in a vector of n elements of the given width, with
  // element 0 in the most significant position.
  function automatic int elem_msb(input int idx, input int width, input int n);
    return width * (n - idx) - 1;
  endfunction

endpackage

// File: rtl/n2r_slice_bank.sv
// One slice bank: SLICE_ROWS rows of WIDTH*COL bits.
// Ports:
//   clk          rising-edge clock
//   wr_en        write wr_data into row wr_row
//   wr_row       row address within the slice
//   wr_data      one matrix row, column 0 in MSBs
//   rd_blk       column block to extract (0..CBLKS-1)
//   rd_transpose emit each block transposed
//   rd_data      one block per core, core 0 in MSBs (combinational)
module n2r_slice_bank
  import n2r_stream_buffer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_CORES  = 4,
  parameter int COL        = 64
) (
  input  logic                                        clk,
  input  logic                                        wr_en,
  input  logic [cnt_w(BLOCK_SIZE*NUM_CORES)-1:0]      wr_row,
  input  logic [WIDTH*COL-1:0]                        wr_data,
  input  logic [cnt_w(COL/BLOCK_SIZE)-1:0]            rd_blk,
  input  logic                                        rd_transpose,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0] rd_data
);

  localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
  localparam int BLK        = BLOCK_SIZE * BLOCK_SIZE;
  localparam int OUT_ELEMS  = BLK * NUM_CORES;

  // Contents are not reset: a reset only discards status, not data.
  logic [SLICE_ROWS-1:0][WIDTH*COL-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_row] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Core c takes rows c*BS..c*BS+BS-1; the selected column block picks the
  // BS columns starting at rd_blk*BS.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        for (int j = 0; j < BLOCK_SIZE; j++) begin
          rd_data[elem_msb(c * BLK + blk_idx(i, j, BLOCK_SIZE, rd_transpose), WIDTH, OUT_ELEMS) -: WIDTH] =
            mem_q[c * BLOCK_SIZE + i][elem_msb(int'(rd_blk) * BLOCK_SIZE + j, WIDTH, COL) -: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/n2r_stream_buffer.sv
// Row-to-block stream buffer. Accepts matrix rows and emits, per column
// block, one BLOCK_SIZE x BLOCK_SIZE block for each of NUM_CORES cores.
// Two slice banks ping-pong so one can fill while the other drains.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  row handshake; in_data is one row, column 0 in MSBs
//   transpose       block transpose mode, sampled on a frame's first row
//   out_valid/ready beat handshake; out_data one block per core, core 0 MSBs
//   out_slice_last  last column block of a slice
//   out_frame_last  last beat of the last slice of a frame
module n2r_stream_buffer
  import n2r_stream_buffer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_CORES  = 4,
  parameter int ROW        = 64,
  parameter int COL        = 64
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [WIDTH*COL-1:0]                             in_data,
  input  logic                                             transpose,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0] out_data,
  output logic                                             out_slice_last,
  output logic                                             out_frame_last
);

  localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
  localparam int CBLKS      = COL / BLOCK_SIZE;
  localparam int NSLICES    = ROW / SLICE_ROWS;
  localparam int OW         = WIDTH * BLOCK_SIZE * BLOCK_SIZE * NUM_CORES;
  localparam int RW         = cnt_w(SLICE_ROWS);
  localparam int CW         = cnt_w(CBLKS);
  localparam int SW         = cnt_w(NSLICES);

  localparam logic [RW-1:0] LAST_ROW   = RW'(SLICE_ROWS - 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(CBLKS - 1);
  localparam logic [SW-1:0] LAST_SLICE = SW'(NSLICES - 1);

  bank_st_e        st_q [2];
  bank_st_e        st_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   slice_q, slice_d;
  logic            tr_q, tr_d;             // frame transpose latch
  logic [1:0]      bank_tr_q, bank_tr_d;   // mode captured per bank
  logic [1:0]      bank_last_q, bank_last_d; // bank holds frame's last slice
  logic            init_q, init_d;         // holds in_ready low through reset

  logic            in_fire, out_fire;
  logic [OW-1:0]   bank_rd [2];

  assign in_ready  = init_q && (st_q[wr_ptr_q] == BANK_EMPTY || st_q[wr_ptr_q] == BANK_FILLING);
  assign out_valid = (st_q[rd_ptr_q] == BANK_FULL) || (st_q[rd_ptr_q] == BANK_DRAINING);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data       = bank_rd[rd_ptr_q];
  assign out_slice_last = out_valid && (beat_q == LAST_BEAT);
  assign out_frame_last = out_slice_last && bank_last_q[rd_ptr_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    n2r_slice_bank #(
      .WIDTH      (WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE),
      .NUM_CORES  (NUM_CORES),
      .COL        (COL)
    ) u_bank (
      .clk          (clk),
      .wr_en        (in_fire && (wr_ptr_q == 1'(b))),
      .wr_row       (row_q),
      .wr_data      (in_data),
      .rd_blk       (beat_q),
      .rd_transpose (bank_tr_q[b]),
      .rd_data      (bank_rd[b])
    );
  end

  always_comb begin
    st_d        = st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    row_d       = row_q;
    beat_d      = beat_q;
    slice_d     = slice_q;
    tr_d        = tr_q;
    bank_tr_d   = bank_tr_q;
    bank_last_d = bank_last_q;
    init_d      = 1'b1;

    // Write side. The fill and drain bank never share a status, so the two
    // halves below never touch the same st_d entry in one cycle.
    if (in_fire) begin
      if (row_q == '0) begin
        // First row of a frame latches the mode; later slices inherit it.
        if (slice_q == '0) begin
          tr_d                = transpose;
          bank_tr_d[wr_ptr_q] = transpose;
        end else begin
          bank_tr_d[wr_ptr_q] = tr_q;
        end
        bank_last_d[wr_ptr_q] = (slice_q == LAST_SLICE);
      end
      if (row_q == LAST_ROW) begin
        st_d[wr_ptr_q] = BANK_FULL;
        row_d          = '0;
        wr_ptr_d       = ~wr_ptr_q;
        slice_d        = (slice_q == LAST_SLICE) ? '0 : slice_q + 1'b1;
      end else begin
        st_d[wr_ptr_q] = BANK_FILLING;
        row_d          = row_q + 1'b1;
      end
    end

    // Read side: a bank becomes valid the cycle after it is FULL.
    if (out_valid) begin
      if (out_fire && beat_q == LAST_BEAT) begin
        st_d[rd_ptr_q] = BANK_EMPTY;
        beat_d         = '0;
        rd_ptr_d       = ~rd_ptr_q;
      end else begin
        st_d[rd_ptr_q] = BANK_DRAINING;
        if (out_fire) beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]     <= BANK_EMPTY;
      st_q[1]     <= BANK_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      row_q       <= '0;
      beat_q      <= '0;
      slice_q     <= '0;
      tr_q        <= 1'b0;
      bank_tr_q   <= '0;
      bank_last_q <= '0;
      init_q      <= 1'b0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      row_q       <= row_d;
      beat_q      <= beat_d;
      slice_q     <= slice_d;
      tr_q        <= tr_d;
      bank_tr_q   <= bank_tr_d;
      bank_last_q <= bank_last_d;
      init_q      <= init_d;
    end
  end

endmodule
